cpu: RTL and testbench

CPU -- requirements
Module: cpu

---
 rtl/cpu_pkg.sv | 48 ++++
 rtl/cpu_regfile.sv | 41 ++++
 rtl/cpu.sv | 198 +++++++++++++++++++
 tb/tb_cpu.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the single-cycle MIPS32 subset core.
// Holds the opcode and funct encodings, the ALU operation set and the
// small selector enums used by the decoder in cpu. Imported by cpu.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  typedef enum logic [1:0] {B_REG, B_SEXT, B_ZEXT} b_sel_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_LINK} wb_sel_e;
  typedef enum logic [1:0] {DST_RD, DST_RT, DST_RA} dst_sel_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 32 x DATA_W register file: two combinational read ports, one write port
// on the rising clk edge. $0 is never written and always reads zero.
// Reads in the same cycle as a write return the old contents.
// Ports: clk, rst (sync, active-high, clears all registers),
//        ra1/ra2 -> rd1/rd2 read ports, we/wa/wd write port,
//        r31/r23/r5 live debug views.
module cpu_regfile #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [4:0]        wa,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] r31,
  output logic [DATA_W-1:0] r23,
  output logic [DATA_W-1:0] r5
);

  logic [DATA_W-1:0] regs [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

  assign r31 = regs[31];
  assign r23 = regs[23];
  assign r5  = regs[5];

endmodule

// File: rtl/cpu.sv
// Single-cycle MIPS32 subset core: one instruction retires per clk edge.
// Decode, ALU and next-pc selection are combinational from inst and the
// register file; only pc and the register file hold state.
// Ports: clk, rst (sync, active-high), inst (instruction at pc),
//        pc (registered), mem_addr/wren/mem_write_data (data-memory
//        request, combinational), mem_read_data (load data),
//        r31/r23/r5 (debug register views).
module cpu
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_read_data,
  output logic        wren,
  output logic [31:0] mem_write_data,
  output logic [31:0] r31,
  output logic [31:0] r23,
  output logic [31:0] r5
);

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] sext_imm, rs_data, rt_data, alu_b, alu_y, wb_data;
  logic [31:0] pc_plus4, pc_next;
  logic [4:0]  wa;

  alu_op_e  alu_op;
  b_sel_e   b_sel;
  wb_sel_e  wb_sel;
  dst_sel_e dst_sel;
  logic     reg_write, store, br_eq, br_ne, jump, jump_reg;

  assign opcode   = inst[31:26];
  assign rs       = inst[25:21];
  assign rt       = inst[20:16];
  assign rd       = inst[15:11];
  assign shamt    = inst[10:6];
  assign funct    = inst[5:0];
  assign imm      = inst[15:0];
  assign sext_imm = sext16(imm);

  // Decoder. Everything defaults to a NOP so unknown encodings fall through.
  always_comb begin
    alu_op    = ALU_ADD;
    b_sel     = B_REG;
    wb_sel    = WB_ALU;
    dst_sel   = DST_RD;
    reg_write = 1'b0;
    store     = 1'b0;
    br_eq     = 1'b0;
    br_ne     = 1'b0;
    jump      = 1'b0;
    jump_reg  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        reg_write = 1'b1;
        case (funct)
          FN_ADDU: alu_op = ALU_ADD;
          FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLTU: alu_op = ALU_SLTU;
          FN_SLL:  alu_op = ALU_SLL;
          FN_SRL:  alu_op = ALU_SRL;
          FN_SRA:  alu_op = ALU_SRA;
          FN_JR: begin
            reg_write = 1'b0;
            jump_reg  = 1'b1;
          end
          FN_JALR: begin
            jump_reg = 1'b1;
            wb_sel   = WB_LINK;
          end
          default: reg_write = 1'b0;
        endcase
      end
      OP_J:   jump = 1'b1;
      OP_JAL: begin
        jump      = 1'b1;
        reg_write = 1'b1;
        dst_sel   = DST_RA;
        wb_sel    = WB_LINK;
      end
      OP_BEQ: br_eq = 1'b1;
      OP_BNE: br_ne = 1'b1;
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        reg_write = 1'b1;
        dst_sel   = DST_RT;
        b_sel     = B_SEXT;
        case (opcode)
          OP_SLTI:  alu_op = ALU_SLT;
          OP_SLTIU: alu_op = ALU_SLTU;
          OP_ANDI: begin alu_op = ALU_AND; b_sel = B_ZEXT; end
          OP_ORI:  begin alu_op = ALU_OR;  b_sel = B_ZEXT; end
          OP_XORI: begin alu_op = ALU_XOR; b_sel = B_ZEXT; end
          OP_LUI:   alu_op = ALU_LUI;
          default:  alu_op = ALU_ADD;
        endcase
      end
      OP_LW: begin
        reg_write = 1'b1;
        dst_sel   = DST_RT;
        b_sel     = B_SEXT;
        wb_sel    = WB_MEM;
      end
      OP_SW: begin
        b_sel = B_SEXT;
        store = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (b_sel)
      B_SEXT:  alu_b = sext_imm;
      B_ZEXT:  alu_b = {16'h0, imm};
      default: alu_b = rt_data;
    endcase
  end

  // Shifts operate on the second operand (rt) by shamt.
  always_comb begin
    case (alu_op)
      ALU_SUB:  alu_y = rs_data - alu_b;
      ALU_AND:  alu_y = rs_data & alu_b;
      ALU_OR:   alu_y = rs_data | alu_b;
      ALU_XOR:  alu_y = rs_data ^ alu_b;
      ALU_NOR:  alu_y = ~(rs_data | alu_b);
      ALU_SLT:  alu_y = {31'h0, $signed(rs_data) < $signed(alu_b)};
      ALU_SLTU: alu_y = {31'h0, rs_data < alu_b};
      ALU_SLL:  alu_y = alu_b << shamt;
      ALU_SRL:  alu_y = alu_b >> shamt;
      ALU_SRA:  alu_y = $unsigned($signed(alu_b) >>> shamt);
      ALU_LUI:  alu_y = {imm, 16'h0};
      default:  alu_y = rs_data + alu_b;
    endcase
  end

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    pc_next = pc_plus4;
    if (jump_reg)
      pc_next = rs_data;
    else if (jump)
      pc_next = {pc_plus4[31:28], inst[25:0], 2'b00};
    else if ((br_eq && rs_data == rt_data) || (br_ne && rs_data != rt_data))
      pc_next = pc_plus4 + {sext_imm[29:0], 2'b00};
  end

  always_comb begin
    case (wb_sel)
      WB_MEM:  wb_data = mem_read_data;
      WB_LINK: wb_data = pc_plus4;
      default: wb_data = alu_y;
    endcase
    case (dst_sel)
      DST_RT:  wa = rt;
      DST_RA:  wa = 5'd31;
      default: wa = rd;
    endcase
  end

  assign mem_addr       = alu_y;
  assign mem_write_data = rt_data;
  assign wren           = store & ~rst;

  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_PC;
    else     pc <= pc_next;
  end

  cpu_regfile #(.DATA_W(32)) u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rs_data),
    .rd2 (rt_data),
    .we  (reg_write & ~rst),
    .wa  (wa),
    .wd  (wb_data),
    .r31 (r31),
    .r23 (r23),
    .r5  (r5)
  );

endmodule

// File: tb/tb_cpu.sv
module tb_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inst = 32'h0;
  logic [31:0] pc, mem_addr, mem_read_data, mem_write_data, r31, r23, r5;
  logic        wren;

  int checks = 0;
  int errors = 0;

  cpu #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .inst           (inst),
    .pc             (pc),
    .mem_addr       (mem_addr),
    .mem_read_data  (mem_read_data),
    .wren           (wren),
    .mem_write_data (mem_write_data),
    .r31            (r31),
    .r23            (r23),
    .r5             (r5)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [4:0] rs_f, input logic [4:0] rt_f,
                                        input logic [4:0] rd_f, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs_f, rt_f, rd_f, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs_f,
                                        input logic [4:0] rt_f, input logic [15:0] im);
    return {op, rs_f, rt_f, im};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  // Apply one instruction and let it retire; returns 1 ns after the edge.
  task automatic exec(input logic [31:0] i);
    inst = i;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    inst = enc_i(6'h2B, 5'd0, 5'd5, 16'h1600);
    #1;
    checks++; if (wren !== 1'b0) begin errors++; $display("FAIL reset_wren got=%b exp=0", wren); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (r31 !== 32'h0 || r23 !== 32'h0 || r5 !== 32'h0) begin
      errors++; $display("FAIL reset_regs got=%h/%h/%h exp=0/0/0", r31, r23, r5); end
    checks++; if (wren !== 1'b0) begin errors++; $display("FAIL reset_wren_hold got=%b exp=0", wren); end
    rst = 1'b0;
  endtask

  task automatic test_alu();
    exec(enc_i(6'h0D, 5'd0, 5'd5, 16'h0030));           // ori $5,$0,0x30
    checks++; if (r5 !== 32'h30) begin errors++; $display("FAIL alu_ori got=%h exp=%h", r5, 32'h30); end
    exec(enc_i(6'h09, 5'd5, 5'd23, 16'hFFFF));          // addiu $23,$5,-1
    checks++; if (r23 !== 32'h2F) begin errors++; $display("FAIL alu_addiu got=%h exp=%h", r23, 32'h2F); end
    exec(enc_i(6'h0F, 5'd0, 5'd5, 16'h1234));           // lui $5,0x1234
    checks++; if (r5 !== 32'h1234_0000) begin errors++; $display("FAIL alu_lui got=%h exp=%h", r5, 32'h1234_0000); end
    exec(enc_r(5'd5, 5'd23, 5'd31, 5'd0, 6'h21));       // addu $31,$5,$23
    checks++; if (r31 !== 32'h1234_002F) begin errors++; $display("FAIL alu_addu got=%h exp=%h", r31, 32'h1234_002F); end
    exec(enc_r(5'd23, 5'd5, 5'd31, 5'd0, 6'h23));       // subu $31,$23,$5
    checks++; if (r31 !== 32'hEDCC_002F) begin errors++; $display("FAIL alu_subu got=%h exp=%h", r31, 32'hEDCC_002F); end
    exec(enc_r(5'd5, 5'd0, 5'd31, 5'd0, 6'h27));        // nor $31,$5,$0
    checks++; if (r31 !== 32'hEDCB_FFFF) begin errors++; $display("FAIL alu_nor got=%h exp=%h", r31, 32'hEDCB_FFFF); end
    exec(enc_r(5'd0, 5'd31, 5'd31, 5'd4, 6'h03));       // sra $31,$31,4
    checks++; if (r31 !== 32'hFEDC_BFFF) begin errors++; $display("FAIL alu_sra got=%h exp=%h", r31, 32'hFEDC_BFFF); end
    exec(enc_r(5'd0, 5'd31, 5'd31, 5'd8, 6'h02));       // srl $31,$31,8
    checks++; if (r31 !== 32'h00FE_DCBF) begin errors++; $display("FAIL alu_srl got=%h exp=%h", r31, 32'h00FE_DCBF); end
    exec(enc_r(5'd0, 5'd5, 5'd31, 5'd4, 6'h00));        // sll $31,$5,4
    checks++; if (r31 !== 32'h2340_0000) begin errors++; $display("FAIL alu_sll got=%h exp=%h", r31, 32'h2340_0000); end
    exec(enc_i(6'h0E, 5'd23, 5'd23, 16'h00FF));         // xori $23,$23,0xFF
    checks++; if (r23 !== 32'hD0) begin errors++; $display("FAIL alu_xori got=%h exp=%h", r23, 32'hD0); end
    exec(enc_i(6'h0C, 5'd23, 5'd23, 16'h0090));         // andi $23,$23,0x90
    checks++; if (r23 !== 32'h90) begin errors++; $display("FAIL alu_andi got=%h exp=%h", r23, 32'h90); end
    exec(enc_r(5'd23, 5'd5, 5'd23, 5'd0, 6'h25));       // or $23,$23,$5
    checks++; if (r23 !== 32'h1234_0090) begin errors++; $display("FAIL alu_or got=%h exp=%h", r23, 32'h1234_0090); end
    exec(enc_r(5'd23, 5'd31, 5'd23, 5'd0, 6'h24));      // and $23,$23,$31
    checks++; if (r23 !== 32'h0200_0000) begin errors++; $display("FAIL alu_and got=%h exp=%h", r23, 32'h0200_0000); end
    exec(enc_i(6'h0B, 5'd23, 5'd5, 16'hFFFF));          // sltiu $5,$23,-1
    checks++; if (r5 !== 32'h1) begin errors++; $display("FAIL alu_sltiu got=%h exp=%h", r5, 32'h1); end
    exec(enc_i(6'h0A, 5'd23, 5'd5, 16'hFFFF));          // slti $5,$23,-1
    checks++; if (r5 !== 32'h0) begin errors++; $display("FAIL alu_slti got=%h exp=%h", r5, 32'h0); end
    checks++; if (pc !== 32'h3C) begin errors++; $display("FAIL alu_pc got=%h exp=%h", pc, 32'h3C); end
  endtask

  task automatic test_memory();
    exec(enc_i(6'h0D, 5'd0, 5'd5, 16'h0030));           // ori $5,$0,0x30
    inst = enc_i(6'h2B, 5'd0, 5'd5, 16'h1600);          // sw $5,0x1600($0)
    #1;
    checks++; if (wren !== 1'b1) begin errors++; $display("FAIL sw_wren got=%b exp=1", wren); end
    checks++; if (mem_addr !== 32'h1600) begin errors++; $display("FAIL sw_addr got=%h exp=%h", mem_addr, 32'h1600); end
    checks++; if (mem_write_data !== 32'h30) begin errors++; $display("FAIL sw_data got=%h exp=%h", mem_write_data, 32'h30); end
    @(posedge clk); #1;
    mem_read_data = 32'h30;
    inst = enc_i(6'h23, 5'd0, 5'd23, 16'h1600);         // lw $23,0x1600($0)
    #1;
    checks++; if (wren !== 1'b0 || mem_addr !== 32'h1600) begin
      errors++; $display("FAIL lw_req got=%b/%h exp=0/%h", wren, mem_addr, 32'h1600); end
    @(posedge clk); #1;
    checks++; if (r23 !== 32'h30) begin errors++; $display("FAIL lw_data got=%h exp=%h", r23, 32'h30); end
    mem_read_data = 32'h0;
    inst = enc_i(6'h2B, 5'd5, 5'd23, 16'hFFFC);         // sw $23,-4($5)
    #1;
    checks++; if (mem_addr !== 32'h2C || mem_write_data !== 32'h30 || wren !== 1'b1) begin
      errors++; $display("FAIL sw_negoff got=%h/%h/%b exp=%h/%h/1", mem_addr, mem_write_data, wren, 32'h2C, 32'h30); end
    @(posedge clk); #1;
  endtask

  task automatic test_control();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exec(32'h0);
    exec(32'h0);
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL ctl_pre got=%h exp=%h", pc, 32'h8); end
    exec(enc_j(6'h03, 26'h10));                          // jal 0x40
    checks++; if (r31 !== 32'hC || pc !== 32'h40) begin
      errors++; $display("FAIL ctl_jal got=%h/%h exp=%h/%h", r31, pc, 32'hC, 32'h40); end
    exec(enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08));        // jr $31
    checks++; if (pc !== 32'hC) begin errors++; $display("FAIL ctl_jr got=%h exp=%h", pc, 32'hC); end
    exec(enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));           // beq $0,$0,-1
    checks++; if (pc !== 32'hC) begin errors++; $display("FAIL ctl_beq_self got=%h exp=%h", pc, 32'hC); end
    exec(enc_i(6'h05, 5'd0, 5'd0, 16'h0005));           // bne $0,$0,5 (not taken)
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL ctl_bne_nt got=%h exp=%h", pc, 32'h10); end
    exec(enc_i(6'h04, 5'd0, 5'd0, 16'h0003));           // beq $0,$0,3
    checks++; if (pc !== 32'h20) begin errors++; $display("FAIL ctl_beq_fwd got=%h exp=%h", pc, 32'h20); end
    exec(enc_i(6'h05, 5'd31, 5'd0, 16'hFFFE));          // bne $31,$0,-2
    checks++; if (pc !== 32'h1C) begin errors++; $display("FAIL ctl_bne_t got=%h exp=%h", pc, 32'h1C); end
    exec(enc_j(6'h02, 26'h40));                          // j 0x100
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL ctl_j got=%h exp=%h", pc, 32'h100); end
    exec(enc_r(5'd31, 5'd0, 5'd23, 5'd0, 6'h09));       // jalr $23,$31
    checks++; if (pc !== 32'hC || r23 !== 32'h104) begin
      errors++; $display("FAIL ctl_jalr got=%h/%h exp=%h/%h", pc, r23, 32'hC, 32'h104); end
  endtask

  task automatic test_boundary();
    logic [31:0] p;
    exec(enc_i(6'h0D, 5'd0, 5'd5, 16'h0007));           // ori $5,$0,7
    exec(enc_i(6'h09, 5'd0, 5'd0, 16'h0005));           // addiu $0,$0,5
    exec(enc_r(5'd0, 5'd0, 5'd5, 5'd0, 6'h21));         // addu $5,$0,$0
    checks++; if (r5 !== 32'h0) begin errors++; $display("FAIL bnd_zero_reg got=%h exp=%h", r5, 32'h0); end
    exec(enc_r(5'd0, 5'd0, 5'd23, 5'd0, 6'h27));        // nor $23,$0,$0
    exec(enc_i(6'h0D, 5'd0, 5'd5, 16'h0001));           // ori $5,$0,1
    exec(enc_r(5'd23, 5'd5, 5'd31, 5'd0, 6'h2A));       // slt $31,$23,$5
    checks++; if (r31 !== 32'h1) begin errors++; $display("FAIL bnd_slt got=%h exp=%h", r31, 32'h1); end
    exec(enc_r(5'd23, 5'd5, 5'd31, 5'd0, 6'h2B));       // sltu $31,$23,$5
    checks++; if (r31 !== 32'h0) begin errors++; $display("FAIL bnd_sltu got=%h exp=%h", r31, 32'h0); end
    p = pc;
    inst = enc_i(6'h28, 5'd0, 5'd5, 16'h0010);          // unsupported opcode (sb)
    #1;
    checks++; if (wren !== 1'b0) begin errors++; $display("FAIL bnd_undef_wren got=%b exp=0", wren); end
    @(posedge clk); #1;
    checks++; if (pc !== p + 32'd4 || r5 !== 32'h1) begin
      errors++; $display("FAIL bnd_undef_op got=%h/%h exp=%h/%h", pc, r5, p + 32'd4, 32'h1); end
    exec(enc_r(5'd0, 5'd0, 5'd5, 5'd0, 6'h3F));         // unsupported funct
    checks++; if (pc !== p + 32'd8 || r5 !== 32'h1) begin
      errors++; $display("FAIL bnd_undef_fn got=%h/%h exp=%h/%h", pc, r5, p + 32'd8, 32'h1); end
  endtask

  task automatic test_midrun_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exec(enc_i(6'h0D, 5'd0, 5'd5, 16'h0055));
    exec(enc_i(6'h0D, 5'd0, 5'd23, 16'h0066));
    exec(enc_j(6'h03, 26'h10));                          // jal 0x40 from pc 8
    checks++; if (pc !== 32'h40 || r31 !== 32'hC || r5 !== 32'h55) begin
      errors++; $display("FAIL mid_setup got=%h/%h/%h exp=%h/%h/%h", pc, r31, r5, 32'h40, 32'hC, 32'h55); end
    rst = 1'b1;
    exec(enc_i(6'h0D, 5'd0, 5'd5, 16'h0077));           // in-flight, discarded
    rst = 1'b0;
    checks++; if (pc !== 32'h0 || r5 !== 32'h0 || r23 !== 32'h0 || r31 !== 32'h0) begin
      errors++; $display("FAIL mid_reset got=%h/%h/%h/%h exp=0/0/0/0", pc, r5, r23, r31); end
    exec(enc_i(6'h0D, 5'd0, 5'd5, 16'h0001));
    checks++; if (pc !== 32'h4 || r5 !== 32'h1) begin
      errors++; $display("FAIL mid_resume got=%h/%h exp=%h/%h", pc, r5, 32'h4, 32'h1); end
  endtask

  initial begin
    mem_read_data = 32'h0;
    test_reset();
    test_alu();
    test_memory();
    test_control();
    test_boundary();
    test_midrun_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
